exe_stage: RTL and testbench



---
 rtl/exe_stage_pkg.sv | 76 +++++++
 rtl/div_iter.sv | 87 ++++++++
 rtl/exe_stage.sv | 117 +++++++++++
 tb/tb_exe_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types for the execute stage: ID/EXE/MEM bundle layouts, op codes and the ALU.
// Bundle field order matches the packed buses exchanged with ID and MEMU.
package exe_stage_pkg;

  localparam int unsigned ID2EXE_LEN  = 155;
  localparam int unsigned EXE2MEM_LEN = 75;

  typedef enum logic [2:0] {
    MdNone, MdMulW, MdMulhW, MdMulhWu, MdDivW, MdModW, MdDivWu, MdModWu
  } md_op_e;

  localparam logic [3:0] MemB  = 4'd0;
  localparam logic [3:0] MemH  = 4'd1;
  localparam logic [3:0] MemW  = 4'd2;
  localparam logic [3:0] MemBu = 4'd8;
  localparam logic [3:0] MemHu = 4'd9;

  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluNor  = 5;
  localparam int unsigned AluOr   = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    md_op_e      md_op;
    logic [3:0]  mem_op;
    logic        mem_we;
    logic [31:0] st_data;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } id2exe_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [3:0]  mem_op;
    logic [31:0] pc;
  } exe2mem_t;

  // One-hot op select; lui expects src2 to already hold the shifted immediate.
  function automatic logic [31:0] alu_calc(input logic [11:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (op[AluAdd])  r |= a + b;
    if (op[AluSub])  r |= a - b;
    if (op[AluSlt])  r |= {31'b0, $signed(a) < $signed(b)};
    if (op[AluSltu]) r |= {31'b0, a < b};
    if (op[AluAnd])  r |= a & b;
    if (op[AluNor])  r |= ~(a | b);
    if (op[AluOr])   r |= a | b;
    if (op[AluXor])  r |= a ^ b;
    if (op[AluSll])  r |= a << b[4:0];
    if (op[AluSrl])  r |= a >> b[4:0];
    if (op[AluSra])  r |= $unsigned($signed(a) >>> b[4:0]);
    if (op[AluLui])  r |= b;
    return r;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider, one quotient bit per cycle over 32 steps.
// Works on magnitudes and applies the sign fix on the way out.
module div_iter import exe_stage_pkg::*; (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        ack_i,
  output logic        done_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [32:0] trial, diff;
  logic        ge;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // A zero divisor always "fits", giving all-ones quotient and the dividend as remainder.
  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StBusy;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = (signed_i & dividend_i[31]) ? -dividend_i : dividend_i;
          dvs_d   = (signed_i & divisor_i[31]) ? -divisor_i : divisor_i;
          q_neg_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
          r_neg_d = signed_i & dividend_i[31];
        end
      end
      StBusy: begin
        rem_d = ge ? diff[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        if (ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_o = (state_q == StDone);
    q_o    = q_neg_q ? -quo_q : quo_q;
    r_o    = r_neg_q ? -rem_q : rem_q;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, multiplier, iterative divider and data-SRAM request generation.
// Holds one instruction and forwards results/hazard info back to ID.
module exe_stage import exe_stage_pkg::*; (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   exe_allowin,
  input  logic                   id_to_exe_valid,
  input  logic [ID2EXE_LEN-1:0]  id_to_exe_zip,
  input  logic                   mem_allowin,
  output logic                   exe_to_mem_valid,
  output logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
  output logic                   data_sram_en,
  output logic [3:0]             data_sram_we,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata,
  output logic [38:0]            exe_rf_zip
);

  id2exe_t     bundle_q, bundle_d;
  exe2mem_t    to_mem;
  logic        exe_valid_q, exe_valid_d;
  logic        is_div, div_signed, div_done, exe_ready_go, mul_signed, pending;
  logic [31:0] alu_result, div_q, div_r, result;
  logic [63:0] product;
  logic [3:0]  st_mask;

  assign is_div       = bundle_q.md_op >= MdDivW;
  assign div_signed   = (bundle_q.md_op == MdDivW) || (bundle_q.md_op == MdModW);
  assign exe_ready_go = ~is_div | div_done;
  assign exe_allowin  = ~exe_valid_q | (exe_ready_go & mem_allowin);

  always_comb begin
    exe_valid_d = exe_valid_q;
    bundle_d    = bundle_q;
    if (exe_allowin) exe_valid_d = id_to_exe_valid;
    if (id_to_exe_valid & exe_allowin) bundle_d = id2exe_t'(id_to_exe_zip);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign alu_result = alu_calc(bundle_q.alu_op, bundle_q.alu_src1, bundle_q.alu_src2);

  // Extend to 64 bits so one multiplier serves both signed and unsigned high halves.
  assign mul_signed = bundle_q.md_op != MdMulhWu;
  assign product = {{32{mul_signed & bundle_q.alu_src1[31]}}, bundle_q.alu_src1} *
                   {{32{mul_signed & bundle_q.alu_src2[31]}}, bundle_q.alu_src2};

  div_iter u_div_iter (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (exe_valid_q & is_div),
    .signed_i   (div_signed),
    .dividend_i (bundle_q.alu_src1),
    .divisor_i  (bundle_q.alu_src2),
    .ack_i      (mem_allowin),
    .done_o     (div_done),
    .q_o        (div_q),
    .r_o        (div_r)
  );

  always_comb begin
    result = alu_result;
    case (bundle_q.md_op)
      MdNone:             result = alu_result;
      MdMulW:             result = product[31:0];
      MdMulhW, MdMulhWu:  result = product[63:32];
      MdDivW, MdDivWu:    result = div_q;
      default:            result = div_r;
    endcase
  end

  assign data_sram_en   = exe_valid_q & (bundle_q.res_from_mem | bundle_q.mem_we) &
                          exe_ready_go & mem_allowin;
  assign data_sram_addr = alu_result;

  always_comb begin
    st_mask         = 4'b1111;
    data_sram_wdata = bundle_q.st_data;
    case (bundle_q.mem_op[1:0])
      2'd0: begin
        st_mask         = 4'b0001 << alu_result[1:0];
        data_sram_wdata = {4{bundle_q.st_data[7:0]}};
      end
      2'd1: begin
        st_mask         = alu_result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{bundle_q.st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign data_sram_we = (data_sram_en & bundle_q.mem_we) ? st_mask : 4'b0000;

  assign exe_to_mem_valid = exe_valid_q & exe_ready_go;

  always_comb begin
    to_mem.res_from_mem = bundle_q.res_from_mem;
    to_mem.rf_we        = bundle_q.rf_we;
    to_mem.rf_waddr     = bundle_q.rf_waddr;
    to_mem.result       = result;
    to_mem.mem_op       = bundle_q.mem_op;
    to_mem.pc           = bundle_q.pc;
  end
  assign exe_to_mem_zip = to_mem;

  assign pending    = exe_valid_q & (bundle_q.res_from_mem | (is_div & ~exe_ready_go));
  assign exe_rf_zip = {pending, bundle_q.rf_we & exe_valid_q, bundle_q.rf_waddr, result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed plus randomized bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         exe_allowin, id_to_exe_valid, mem_allowin, exe_to_mem_valid;
  logic [154:0] id_to_exe_zip;
  logic [74:0]  exe_to_mem_zip;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic [38:0]  exe_rf_zip;

  exe_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .exe_allowin      (exe_allowin),
    .id_to_exe_valid  (id_to_exe_valid),
    .id_to_exe_zip    (id_to_exe_zip),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_zip   (exe_to_mem_zip),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .exe_rf_zip       (exe_rf_zip)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          c_idx;
  logic [31:0] c_s1, c_s2, c_st, c_pc;
  logic [2:0]  c_md;
  logic [3:0]  c_mop;
  logic        c_we, c_rfm, c_rfwe;
  logic [4:0]  c_wa;
  bit          stall_en;
  int          n_cyc;
  bit          pend_all;
  logic [31:0] got_res, got_addr, got_wd;
  logic [3:0]  got_we;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(int idx, logic [31:0] a, logic [31:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    case (idx)
      0:  return a + b;
      1:  return a - b;
      2:  return (ia < ib) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << (b % 32);
      9:  return a >> (b % 32);
      10: return ia >>> (b % 32);
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(logic [2:0] md, logic [31:0] a, logic [31:0] b,
                                          logic [31:0] alu);
    int ia, ib;
    longint sp;
    longint unsigned up;
    logic [63:0] t;
    ia = a;
    ib = b;
    sp = ia;
    sp = sp * ib;
    up = a;
    up = up * b;
    case (md)
      3'd0: return alu;
      3'd1: begin t = sp; return t[31:0]; end
      3'd2: begin t = sp; return t[63:32]; end
      3'd3: begin t = up; return t[63:32]; end
      3'd4: begin
        if (b == 0) return (ia < 0) ? 32'd1 : 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      3'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic set_ins(int idx, logic [31:0] s1, logic [31:0] s2, logic [2:0] md,
                         logic [3:0] mop, logic we, logic [31:0] st, logic rfm);
    c_idx = idx; c_s1 = s1; c_s2 = s2; c_md = md; c_mop = mop; c_we = we; c_st = st;
    c_rfm = rfm; c_rfwe = ~we; c_wa = 5'($urandom_range(1, 31)); c_pc = $urandom & ~32'd3;
  endtask

  // Present the current instruction, then follow it until MEMU takes it.
  task automatic run();
    logic [11:0] oh;
    logic [31:0] addr, exp_res, exp_wd;
    logic [3:0]  exp_we;
    bit          stray;
    addr    = ref_alu(c_idx, c_s1, c_s2);
    exp_res = ref_md(c_md, c_s1, c_s2, addr);
    exp_we  = 4'b0000;
    exp_wd  = c_st;
    if (c_mop[1:0] == 2'd0) begin
      exp_we = 4'(1 << (addr % 4));
      exp_wd = c_st[7:0] * 32'h0101_0101;
    end else if (c_mop[1:0] == 2'd1) begin
      exp_we = 4'(3 << (addr & 2));
      exp_wd = c_st[15:0] * 32'h0001_0001;
    end else begin
      exp_we = 4'hF;
    end
    if (!c_we) exp_we = 4'b0000;
    oh = '0;
    oh[c_idx] = 1'b1;
    id_to_exe_zip = {oh, c_s1, c_s2, c_md, c_mop, c_we, c_st, c_rfm, c_rfwe, c_wa, c_pc};
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1;
    id_to_exe_valid = 1'b0;
    n_cyc = 0;
    pend_all = 1'b1;
    stray = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      mem_allowin = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (exe_to_mem_valid && mem_allowin) begin
        n_cyc    = n;
        got_res  = exe_to_mem_zip[67:36];
        got_addr = data_sram_addr;
        got_we   = data_sram_we;
        got_wd   = data_sram_wdata;
        chk("zip", exe_to_mem_zip, {c_rfm, c_rfwe, c_wa, exp_res, c_mop, c_pc});
        chk("rf_zip", exe_rf_zip, {c_rfm, c_rfwe, c_wa, exp_res});
        chk("sram_en", data_sram_en, c_rfm | c_we);
        chk("sram_we", data_sram_we, exp_we);
        if (c_rfm | c_we) chk("sram_addr", data_sram_addr, addr);
        if (c_we) chk("sram_wdata", data_sram_wdata, exp_wd);
        break;
      end
      if (!exe_to_mem_valid) pend_all &= exe_rf_zip[38];
      if (data_sram_en) stray = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("handoff_in_budget", n_cyc > 0, 1'b1);
    chk("no_early_sram_en", stray, 1'b0);
    @(posedge clk);
    #1;
    mem_allowin = 1'b1;
  endtask

  initial begin
    logic [3:0] lmops [5];
    int kind;
    lmops = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    resetn = 1'b0;
    id_to_exe_valid = 1'b0;
    id_to_exe_zip = '0;
    mem_allowin = 1'b1;
    stall_en = 1'b0;
    #12;
    chk("rst_allowin", exe_allowin, 1'b1);
    chk("rst_valid", exe_to_mem_valid, 1'b0);
    chk("rst_zip", exe_to_mem_zip, 75'd0);
    chk("rst_rf_zip", exe_rf_zip, 39'd0);
    chk("rst_sram", {data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}, 69'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    set_ins(0, 32'd3, 32'd4, 3'd0, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("add_latency", n_cyc, 1);
    chk("add_result", got_res, 32'd7);
    set_ins(0, 32'h100, 32'd0, 3'd0, 4'd2, 1'b0, 32'd0, 1'b1);
    run();
    chk("ldw_addr", got_addr, 32'h100);
    chk("ldw_we", got_we, 4'b0000);
    set_ins(0, 32'h103, 32'd0, 3'd0, 4'd0, 1'b1, 32'h1234_5678, 1'b0);
    run();
    chk("stb_we", got_we, 4'b1000);
    chk("stb_wdata", got_wd, 32'h7878_7878);
    set_ins(0, 32'h102, 32'd0, 3'd0, 4'd1, 1'b1, 32'h1234_5678, 1'b0);
    run();
    chk("sth_we", got_we, 4'b1100);
    chk("sth_wdata", got_wd, 32'h5678_5678);

    set_ins(0, -32'd7, 32'd2, 3'd4, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("divw_latency", n_cyc, 34);
    chk("divw_pending", pend_all, 1'b1);
    chk("divw_q", got_res, 32'hFFFF_FFFD);
    set_ins(0, -32'd7, 32'd2, 3'd5, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("modw_r", got_res, 32'hFFFF_FFFF);
    set_ins(0, 32'd5, 32'd0, 3'd6, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("divwu_by0", got_res, 32'hFFFF_FFFF);
    set_ins(0, 32'd5, 32'd0, 3'd7, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("modwu_by0", got_res, 32'd5);
    set_ins(0, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("divw_ovf", got_res, 32'h8000_0000);

    // Abort a divide mid-flight with an asynchronous reset.
    id_to_exe_zip = {12'd1, 32'd1000, 32'd3, 3'd6, 4'd2, 1'b0, 32'd0, 1'b0, 1'b1, 5'd9,
                     32'h1c00_0040};
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1;
    id_to_exe_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_valid", exe_to_mem_valid, 1'b0);
    chk("abort_allowin", exe_allowin, 1'b1);
    chk("abort_zip", exe_to_mem_zip, 75'd0);
    chk("abort_rf_zip", exe_rf_zip, 39'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    set_ins(0, 32'd100, 32'd7, 3'd6, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("post_rst_divwu_latency", n_cyc, 34);
    chk("post_rst_divwu_q", got_res, 32'd14);
    set_ins(0, 32'd100, 32'd7, 3'd7, 4'd2, 1'b0, 32'd0, 1'b0);
    run();
    chk("post_rst_modwu_r", got_res, 32'd2);

    stall_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        set_ins($urandom_range(0, 11), $urandom, $urandom, 3'd0, 4'd2, 1'b0, 32'd0, 1'b0);
      end else if (kind < 6) begin
        set_ins(0, $urandom, $urandom, 3'($urandom_range(1, 3)), 4'd2, 1'b0, 32'd0, 1'b0);
      end else if (kind == 6) begin
        set_ins(0, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31),
                3'($urandom_range(4, 7)), 4'd2, 1'b0, 32'd0, 1'b0);
      end else if (kind < 9) begin
        set_ins(0, $urandom, $urandom_range(0, 255), 3'd0, lmops[$urandom_range(0, 4)], 1'b0,
                32'd0, 1'b1);
      end else begin
        set_ins(0, $urandom, $urandom_range(0, 255), 3'd0, 4'($urandom_range(0, 2)), 1'b1,
                $urandom, 1'b0);
      end
      run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
